clock_phase_sequencer: RTL and testbench

Synchronous phase sequencer for the multi-cycle MIPS processor. It replaces free-running divided clocks with single-clock-domain enable strobes for the processor, instruction memory, register file and data memory. Phase high/low lengths are programmable per channel. The block adds run, halt and single-step control, so that a debug or boot controller can start, stop and step the processor on whole-cycle boundaries only.

---
 rtl/clock_phase_sequencer.sv | 81 ++++++++
 tb/tb_clock_phase_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_phase_sequencer.sv
// clock_phase_sequencer: single-clock phase enables for the multi-cycle MIPS core
// with run/halt/single-step control on whole processor-period boundaries.
module clock_phase_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             run_i,
    input  logic             step_req_i,
    input  logic             cfg_we_i,
    input  logic [1:0]       cfg_sel_i,
    input  logic [CNT_W-1:0] cfg_high_i,
    input  logic [CNT_W-1:0] cfg_low_i,
    output logic             proc_en_o,
    output logic             imem_en_o,
    output logic             regfile_en_o,
    output logic             dmem_en_o,
    output logic             proc_tick_o,
    output logic             halted_o,
    output logic             step_ack_o,
    output logic             cfg_err_o
);
    localparam logic [1:0] HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, DRAIN = 2'd3;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] hi_q  [4];
    logic [CNT_W-1:0] lo_q  [4];
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       ph_q, ph_d, last;
    logic             pend, tick_d, tick_q, ack_q, err_q;
    always_comb begin
        for (int i = 0; i < 4; i++)
            last[i] = cnt_q[i] == (ph_q[i] ? hi_q[i] : lo_q[i]) - ONE;
        pend = state_q != HALT && !ph_q[0] && last[0];
        state_d = state_q == HALT ? (run_i ? RUN : step_req_i ? STEP : HALT)
                : state_q == RUN  ? (run_i ? RUN : DRAIN)
                : state_q == STEP ? (pend ? HALT : STEP)
                :                   (run_i ? RUN : pend ? HALT : DRAIN);
        // Every start realigns all channels to the first high cycle.
        for (int i = 0; i < 4; i++) begin
            ph_d[i]  = state_d == HALT ? 1'b0 : state_q == HALT ? 1'b1 : ph_q[i] ^ last[i];
            cnt_d[i] = (state_d == HALT || state_q == HALT || last[i]) ? '0 : cnt_q[i] + ONE;
        end
        tick_d = state_d != HALT && (state_q == HALT || pend);
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= HALT;
            ph_q    <= '0;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
                hi_q[i]  <= i == 2 ? CNT_W'(4) : CNT_W'(3);
                lo_q[i]  <= i == 2 ? CNT_W'(2) : CNT_W'(3);
            end
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            tick_q  <= tick_d;
            ack_q   <= state_q == STEP && pend;
            err_q   <= cfg_we_i && state_q != HALT;
            for (int i = 0; i < 4; i++)
                cnt_q[i] <= cnt_d[i];
            if (cfg_we_i && state_q == HALT) begin
                hi_q[cfg_sel_i] <= cfg_high_i == '0 ? ONE : cfg_high_i;
                lo_q[cfg_sel_i] <= cfg_low_i  == '0 ? ONE : cfg_low_i;
            end
        end
    end
    assign proc_en_o    = ph_q[0];
    assign imem_en_o    = ph_q[1];
    assign regfile_en_o = ph_q[2];
    assign dmem_en_o    = ph_q[3];
    assign proc_tick_o  = tick_q;
    assign halted_o     = state_q == HALT;
    assign step_ack_o   = ack_q;
    assign cfg_err_o    = err_q;
endmodule

// File: tb/tb_clock_phase_sequencer.sv
// tb_clock_phase_sequencer: randomized and directed checks against a
// cycle-position reference model of the phase sequencer.
module tb_clock_phase_sequencer;
    logic       clock = 1'b0, reset = 1'b1, run = 1'b0, step_req = 1'b0, cfg_we = 1'b0;
    logic [1:0] cfg_sel = 2'd0;
    logic [3:0] cfg_high = 4'd0, cfg_low = 4'd0;
    logic       proc_en, imem_en, regfile_en, dmem_en, proc_tick, halted, step_ack, cfg_err;
    int checks = 0, errors = 0;

    // Model: mode 0 halted, 1 running, 2 stepping, 3 draining; k = cycles since start.
    int mode = 0, k = 0;
    int mh[4] = '{3, 3, 4, 3};
    int ml[4] = '{3, 3, 2, 3};
    bit m_ack = 0, m_err = 0;

    clock_phase_sequencer #(.CNT_W(4)) dut (
        .clock_i(clock), .reset_i(reset), .run_i(run), .step_req_i(step_req),
        .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_high_i(cfg_high), .cfg_low_i(cfg_low),
        .proc_en_o(proc_en), .imem_en_o(imem_en), .regfile_en_o(regfile_en), .dmem_en_o(dmem_en),
        .proc_tick_o(proc_tick), .halted_o(halted), .step_ack_o(step_ack), .cfg_err_o(cfg_err)
    );

    always #5 clock = ~clock;

    function automatic bit m_en(int c);
        return mode != 0 && (k % (mh[c] + ml[c])) < mh[c];
    endfunction

    function automatic logic [7:0] expv();
        return {m_en(0), m_en(1), m_en(2), m_en(3),
                mode != 0 && (k % (mh[0] + ml[0])) == 0, mode == 0, m_ack, m_err};
    endfunction

    function automatic logic [7:0] obs();
        return {proc_en, imem_en, regfile_en, dmem_en, proc_tick, halted, step_ack, cfg_err};
    endfunction

    task automatic m_edge();
        bit pend;
        int nxt;
        if (reset) begin
            mode = 0; k = 0; m_ack = 0; m_err = 0;
            mh = '{3, 3, 4, 3};
            ml = '{3, 3, 2, 3};
            return;
        end
        pend  = mode != 0 && (k % (mh[0] + ml[0])) == mh[0] + ml[0] - 1;
        m_ack = mode == 2 && pend;
        m_err = cfg_we && mode != 0;
        if (cfg_we && mode == 0) begin
            mh[cfg_sel] = cfg_high == 0 ? 1 : int'(cfg_high);
            ml[cfg_sel] = cfg_low  == 0 ? 1 : int'(cfg_low);
        end
        case (mode)
            0:       nxt = run ? 1 : step_req ? 2 : 0;
            1:       nxt = run ? 1 : 3;
            2:       nxt = pend ? 0 : 2;
            default: nxt = run ? 1 : pend ? 0 : 3;
        endcase
        k = (nxt == 0 || mode == 0) ? 0 : k + 1;
        mode = nxt;
    endtask

    task automatic cyc();
        @(posedge clock);
        m_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (obs() !== 8'b0000_0100) begin
                errors++;
                $display("FAIL reset: got %b want %b", obs(), 8'b0000_0100);
            end
        end
    endtask

    task automatic test_defaults();
        logic [11:0] pe = '0, re = '0, tk = '0;
        reset = 1'b0; run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            pe[11-i] = proc_en; re[11-i] = regfile_en; tk[11-i] = proc_tick;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL defaults cycle %0d: got %b want %b", i, obs(), expv());
            end
        end
        checks += 3;
        if (pe !== 12'b111000111000) begin errors++; $display("FAIL defaults proc_en: got %b want 111000111000", pe); end
        if (re !== 12'b111100111100) begin errors++; $display("FAIL defaults regfile_en: got %b want 111100111100", re); end
        if (tk !== 12'b100000100000) begin errors++; $display("FAIL defaults proc_tick: got %b want 100000100000", tk); end
        run = 1'b0;
        for (int n = 0; n < 40 && !halted; n++) cyc();
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL defaults stop: halted got %b want 1", halted); end
    endtask

    task automatic test_step();
        logic [5:0] pe = '0;
        int active = 0, ack_at = -1;
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            if (i < 6) pe[5-i] = proc_en;
            if (!halted) active++;
            if (step_ack) ack_at = i;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL step cycle %0d: got %b want %b", i, obs(), expv());
            end
        end
        checks += 3;
        if (pe !== 6'b111000) begin errors++; $display("FAIL step proc_en: got %b want 111000", pe); end
        if (active != 6) begin errors++; $display("FAIL step length: got %0d want 6", active); end
        if (ack_at != 6) begin errors++; $display("FAIL step ack cycle: got %0d want 6", ack_at); end
    endtask

    task automatic test_drain();
        logic [4:0] pe = '0;
        logic [6:0] pg = '0;
        run = 1'b1;
        cyc(); cyc();
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            pe[4-i] = proc_en;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL drain cycle %0d: got %b want %b", i, obs(), expv());
            end
        end
        checks += 2;
        if (pe !== 5'b10000) begin errors++; $display("FAIL drain proc_en: got %b want 10000", pe); end
        if ({halted, proc_en, imem_en, regfile_en, dmem_en} !== 5'b10000) begin
            errors++;
            $display("FAIL drain halt: got %b want 10000", {halted, proc_en, imem_en, regfile_en, dmem_en});
        end
        run = 1'b1;
        cyc(); cyc();
        run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (i == 0) run = 1'b1;
            pg[6-i] = proc_en;
            checks++;
            if (obs() !== expv() || halted) begin
                errors++;
                $display("FAIL drain resume cycle %0d: got %b want %b", i, obs(), expv());
            end
        end
        checks++;
        if (pg !== 7'b1000111) begin errors++; $display("FAIL drain resume proc_en: got %b want 1000111", pg); end
        run = 1'b0;
        for (int n = 0; n < 40 && !halted; n++) cyc();
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL drain final halt: got %b want 1", halted); end
    endtask

    task automatic test_config();
        logic [5:0] re = '0, pe = '0;
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_high = 4'd1; cfg_low = 4'd1;
        cyc();
        cfg_we = 1'b0; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            re[5-i] = regfile_en;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL config A cycle %0d: got %b want %b", i, obs(), expv()); end
        end
        checks++;
        if (re !== 6'b101010) begin errors++; $display("FAIL config regfile_en: got %b want 101010", re); end
        run = 1'b0;
        for (int n = 0; n < 40 && !halted; n++) cyc();
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_high = 4'd0; cfg_low = 4'd2;
        cyc();
        cfg_we = 1'b0; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            pe[5-i] = proc_en;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL config B cycle %0d: got %b want %b", i, obs(), expv()); end
        end
        checks++;
        if (pe !== 6'b100100) begin errors++; $display("FAIL config proc_en: got %b want 100100", pe); end
    endtask

    task automatic test_cfg_err();
        logic [5:0] pe = '0;
        cyc();
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_high = 4'd5; cfg_low = 4'd5;
        cyc();
        cfg_we = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err pulse: got %b want 1", cfg_err); end
        cyc();
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err clear: got %b want 0", cfg_err); end
        run = 1'b0;
        for (int n = 0; n < 40 && !halted; n++) cyc();
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            pe[5-i] = proc_en;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL cfg_err cycle %0d: got %b want %b", i, obs(), expv()); end
        end
        checks++;
        if (pe !== 6'b100100) begin errors++; $display("FAIL cfg_err pattern: got %b want 100100", pe); end
    endtask

    task automatic test_reset_mid_run();
        logic [5:0] pe = '0;
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (obs() !== 8'b0000_0100) begin errors++; $display("FAIL reset mid-run: got %b want 00000100", obs()); end
        for (int i = 0; i < 6; i++) begin
            cyc();
            pe[5-i] = proc_en;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL reset restart cycle %0d: got %b want %b", i, obs(), expv()); end
        end
        checks++;
        if (pe !== 6'b111000) begin errors++; $display("FAIL reset restart proc_en: got %b want 111000", pe); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) run = $urandom_range(0, 2) == 0;
            step_req = $urandom_range(0, 9) == 0;
            cfg_we   = $urandom_range(0, 7) == 0;
            cfg_sel  = 2'($urandom_range(0, 3));
            cfg_high = 4'($urandom_range(0, 5));
            cfg_low  = 4'($urandom_range(0, 5));
            reset    = $urandom_range(0, 149) == 0;
            cyc();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL random cycle %0d: got %b want %b", i, obs(), expv()); end
        end
        {reset, run, step_req, cfg_we} = 4'b0;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_step();
        test_drain();
        test_config();
        test_cfg_err();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
